multi_clock_divider: RTL

Multi-channel programmable clock divider, the parametrised successor to the fixed single-channel divider. Each channel produces a divided clock with run-time factor and high-time (duty) settings, plus a one-cycle period-start strobe. New settings are double-buffered and applied only on a period boundary, so the output never glitches. It sits beside the system clock and generates PWM bases, serial bit clocks and sample strobes for Uniboard peripherals.

---
 rtl/multi_clock_divider.sv | 95 +++++++++
 1 files changed

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider with double-buffered factor/high settings.
// Define MCD_SYNC_EN to add the sync_i input that phase-aligns all enabled channels.
module multi_clock_divider #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
) (
  input  logic                      clk_i,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       en_i,
  input  logic [CHANNELS-1:0]       load_i,
  input  logic [CHANNELS*WIDTH-1:0] factor_i,
  input  logic [CHANNELS*WIDTH-1:0] high_i,
  output logic [CHANNELS-1:0]       clk_o,
  output logic [CHANNELS-1:0]       tick_o
`ifdef MCD_SYNC_EN
  ,
  input  logic                      sync_i
`endif
);

  logic sync_w;
`ifdef MCD_SYNC_EN
  assign sync_w = sync_i;
`else
  assign sync_w = 1'b0;
`endif

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] act_f, act_h;
    logic [WIDTH-1:0] pend_f, pend_h;
    logic             pend;
    logic             clk_q, tick_q;
    logic [WIDTH-1:0] eff_f, eff_h, new_f, new_h;
    logic             boundary;

    assign new_f    = factor_i[n*WIDTH +: WIDTH];
    assign new_h    = high_i[n*WIDTH +: WIDTH];
    assign eff_f    = (act_f < WIDTH'(2)) ? WIDTH'(2) : act_f;
    assign eff_h    = (act_h > eff_f) ? eff_f : act_h;
    assign boundary = (count == eff_f - WIDTH'(1));

    // NOTE: all state here uses non-blocking assignments so every register samples
    // the pre-edge values; blocking would make the result depend on statement order.
    always_ff @(posedge clk_i) begin
      if (reset) begin
        count  <= '0;
        act_f  <= WIDTH'(2);
        act_h  <= WIDTH'(1);
        pend_f <= '0;
        pend_h <= '0;
        pend   <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (!en_i[n] || sync_w) begin
        // Idle/resync: hold phase at zero and apply settings immediately.
        count  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        pend   <= 1'b0;
        if (load_i[n]) begin
          act_f <= new_f;
          act_h <= new_h;
        end else if (pend) begin
          act_f <= pend_f;
          act_h <= pend_h;
        end
      end else begin
        count  <= boundary ? '0 : count + WIDTH'(1);
        clk_q  <= (count >= eff_f - eff_h);
        // Tick from count==0 so it lands in the first (low) output cycle of the period.
        tick_q <= (count == '0);
        if (load_i[n]) begin
          if (boundary) begin
            act_f <= new_f;
            act_h <= new_h;
            pend  <= 1'b0;
          end else begin
            pend_f <= new_f;
            pend_h <= new_h;
            pend   <= 1'b1;
          end
        end else if (boundary && pend) begin
          act_f <= pend_f;
          act_h <= pend_h;
          pend  <= 1'b0;
        end
      end
    end

    assign clk_o[n]  = clk_q;
    assign tick_o[n] = tick_q;
  end

endmodule
